// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, axis-length helper and start/stop FSM state encoding.
package vga_pkg;

  localparam int   DEF_H_VISIBLE = 640;
  localparam int   DEF_H_FRONT   = 16;
  localparam int   DEF_H_SYNC    = 96;
  localparam int   DEF_H_BACK    = 48;
  localparam int   DEF_V_VISIBLE = 480;
  localparam int   DEF_V_FRONT   = 10;
  localparam int   DEF_V_SYNC    = 2;
  localparam int   DEF_V_BACK    = 33;
  localparam logic DEF_HSYNC_POL = 1'b0;
  localparam logic DEF_VSYNC_POL = 1'b0;
  localparam int   DEF_CNT_W     = 11;

  function automatic int axisTotal(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vgaState_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered sync, plus next-value visible/zero decodes.
// Count and Sync update in the same register stage; Wrap is a combinational decode of Count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE = DEF_H_VISIBLE,
  parameter int   FRONT   = DEF_H_FRONT,
  parameter int   SYNC    = DEF_H_SYNC,
  parameter int   BACK    = DEF_H_BACK,
  parameter logic POL     = 1'b0,
  parameter int   CNT_W   = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Step,
  input  logic             Clear,
  output logic [CNT_W-1:0] Count,
  output logic             Wrap,
  output logic             Sync,
  output logic             NextVisible,
  output logic             NextZero
);

  localparam int TOTAL = axisTotal(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(VISIBLE + FRONT + SYNC);

  logic [CNT_W-1:0] cntNext;
  logic             syncNext;

  assign Wrap = (Count == LAST);

  always_comb begin
    cntNext = Count;
    if (Clear) begin
      cntNext = '0;
    end else if (Step) begin
      cntNext = Wrap ? '0 : Count + 1'b1;
    end
  end

  // Decodes look at the next count so they land in the same flop stage as Count.
  assign syncNext    = !Clear && (cntNext >= SYNC_BEG) && (cntNext < SYNC_END);
  assign NextVisible = !Clear && (cntNext < VIS_END);
  assign NextZero    = !Clear && (cntNext == '0);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Count <= '0;
      Sync  <= ~POL;
    end else begin
      Count <= cntNext;
      Sync  <= syncNext ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator with frame-aligned start/stop; Run high to FrameStart is one cycle, no backpressure.
// Define VGA_TIMING_FRAME_IRQ_EN to add the sticky start-of-vblank flag FrameIrq with IrqAck clear.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic HSYNC_POL = DEF_HSYNC_POL,
  parameter logic VSYNC_POL = DEF_VSYNC_POL,
  parameter int   CNT_W     = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Run,
  output logic [CNT_W-1:0] PixX,
  output logic [CNT_W-1:0] PixY,
  output logic             HSync,
  output logic             VSync,
  output logic             DispEn,
  output logic             LineStart,
  output logic             FrameStart,
  output logic             Active
`ifdef VGA_TIMING_FRAME_IRQ_EN
  ,
  input  logic             IrqAck,
  output logic             FrameIrq
`endif
);

  vgaState_e state;
  logic hStep, vStep, cntClear, enterIdle;
  logic hWrap, vWrap, lastPix;
  logic hNextVis, vNextVis, hNextZero, vNextZero;

  assign lastPix   = hWrap && vWrap;
  assign hStep     = (state != IDLE);
  assign vStep     = hStep && hWrap;
  assign enterIdle = (state == DRAIN) && lastPix && !Run;
  // Idle without a request parks both counters at 0 with blanked outputs.
  assign cntClear  = ((state == IDLE) && !Run) || enterIdle;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HSYNC_POL), .CNT_W(CNT_W)
  ) hAxis (
    .Clk(Clk), .RstN(RstN), .Step(hStep), .Clear(cntClear),
    .Count(PixX), .Wrap(hWrap), .Sync(HSync),
    .NextVisible(hNextVis), .NextZero(hNextZero)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VSYNC_POL), .CNT_W(CNT_W)
  ) vAxis (
    .Clk(Clk), .RstN(RstN), .Step(vStep), .Clear(cntClear),
    .Count(PixY), .Wrap(vWrap), .Sync(VSync),
    .NextVisible(vNextVis), .NextZero(vNextZero)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state  <= IDLE;
      Active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            state  <= RUN;
            Active <= 1'b1;
          end
        end
        RUN: begin
          if (!Run) state <= DRAIN;
        end
        DRAIN: begin
          if (Run) begin
            state <= RUN;
          end else if (lastPix) begin
            state  <= IDLE;
            Active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          Active <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      DispEn     <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      DispEn     <= hNextVis && vNextVis;
      LineStart  <= hNextZero;
      FrameStart <= hNextZero && vNextZero;
    end
  end

`ifdef VGA_TIMING_FRAME_IRQ_EN
  localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VISIBLE - 1);
  logic irqSet;

  // Fires on the step that moves PixY into the first blanking line; wins over a same-cycle ack.
  assign irqSet = vStep && (PixY == V_LAST_VIS);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      FrameIrq <= 1'b0;
    end else if (irqSet) begin
      FrameIrq <= 1'b1;
    end else if (IrqAck || enterIdle) begin
      FrameIrq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a reduced 16x12 timing instance for full-frame behaviour plus a default 800x525 instance for one line.
`timescale 1ns/1ps

`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
    end \
  end

module tb_vga_timing_gen;

  localparam int SW = 5;

  logic Clk = 1'b0;
  logic RstN, Run;

  logic [SW-1:0] sPixX, sPixY;
  logic sHSync, sVSync, sDispEn, sLineStart, sFrameStart, sActive;
  logic [10:0] dPixX, dPixY;
  logic dHSync, dVSync, dDispEn, dLineStart, dFrameStart, dActive;
`ifdef VGA_TIMING_FRAME_IRQ_EN
  logic IrqAck, sFrameIrq, dFrameIrq;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  // Small timing: H 8+2+3+3 = 16, V 6+1+2+3 = 12, frame = 192 cycles.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(SW)
  ) dutSmall (
    .Clk(Clk), .RstN(RstN), .Run(Run),
    .PixX(sPixX), .PixY(sPixY), .HSync(sHSync), .VSync(sVSync),
    .DispEn(sDispEn), .LineStart(sLineStart), .FrameStart(sFrameStart),
    .Active(sActive)
`ifdef VGA_TIMING_FRAME_IRQ_EN
    , .IrqAck(IrqAck), .FrameIrq(sFrameIrq)
`endif
  );

  vga_timing_gen dutDefault (
    .Clk(Clk), .RstN(RstN), .Run(Run),
    .PixX(dPixX), .PixY(dPixY), .HSync(dHSync), .VSync(dVSync),
    .DispEn(dDispEn), .LineStart(dLineStart), .FrameStart(dFrameStart),
    .Active(dActive)
`ifdef VGA_TIMING_FRAME_IRQ_EN
    , .IrqAck(IrqAck), .FrameIrq(dFrameIrq)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int dDisp, dHsLow, dHsFirst, dHsLast, dLines;
    int sDisp, sHsLow, sVsLow, sLines, sFrames;
    int x, y, n, lastX, lastY, inact;
    logic expHs, expVs, expDe;
    dDisp = 0; dHsLow = 0; dHsFirst = -1; dHsLast = -1; dLines = 0;
    sDisp = 0; sHsLow = 0; sVsLow = 0; sLines = 0; sFrames = 0;
    lastX = -1; lastY = -1;

    RstN = 1'b0;
    Run  = 1'b0;
`ifdef VGA_TIMING_FRAME_IRQ_EN
    IrqAck = 1'b0;
`endif
    repeat (3) tick();
    tests++;
    if ({sHSync, sVSync, sDispEn, sLineStart, sFrameStart, sActive} !== 6'b110000) begin
      fails++;
      $error("FAIL rst_state: outputs %b not at reset values",
             {sHSync, sVSync, sDispEn, sLineStart, sFrameStart, sActive});
    end
    `CHK("rst_pixx", int'(sPixX), 0)
    `CHK("rst_pixy", int'(sPixY), 0)
    `CHK("rst_hsync", sHSync, 1'b1)
    `CHK("rst_vsync", sVSync, 1'b1)
    `CHK("rst_dispen", sDispEn, 1'b0)
    `CHK("rst_linestart", sLineStart, 1'b0)
    `CHK("rst_framestart", sFrameStart, 1'b0)
    `CHK("rst_active", sActive, 1'b0)
`ifdef VGA_TIMING_FRAME_IRQ_EN
    `CHK("rst_irq", sFrameIrq, 1'b0)
`endif

    @(negedge Clk);
    RstN = 1'b1;
    repeat (3) tick();
    `CHK("idle_active", sActive, 1'b0)
    `CHK("idle_dispen", sDispEn, 1'b0)
    `CHK("idle_hsync", sHSync, 1'b1)
    `CHK("idle_framestart", sFrameStart, 1'b0)

    // Run rises; first registered cycle presents the top-left pixel.
    Run = 1'b1;
    tick();
    `CHK("start_framestart", sFrameStart, 1'b1)
    `CHK("start_linestart", sLineStart, 1'b1)
    `CHK("start_pixx", int'(sPixX), 0)
    `CHK("start_pixy", int'(sPixY), 0)
    `CHK("start_dispen", sDispEn, 1'b1)
    `CHK("start_hsync", sHSync, 1'b1)
    `CHK("start_vsync", sVSync, 1'b1)
    `CHK("start_active", sActive, 1'b1)
    `CHK("dflt_start_framestart", dFrameStart, 1'b1)
    `CHK("dflt_start_pixx", int'(dPixX), 0)
    `CHK("dflt_start_dispen", dDispEn, 1'b1)
    `CHK("dflt_start_hsync", dHSync, 1'b1)

    // Five small frames; the default instance covers its first line in the same window.
    for (int k = 0; k < 960; k++) begin
      x = k % 16;
      y = (k / 16) % 12;
      expHs = (x >= 10 && x < 13) ? 1'b0 : 1'b1;
      expVs = (y >= 7 && y < 9) ? 1'b0 : 1'b1;
      expDe = (x < 8 && y < 6) ? 1'b1 : 1'b0;
      tests++;
      if (int'(sPixX) !== x) begin
        fails++;
        $error("FAIL run_pixx: observed %0d expected %0d", sPixX, x);
      end
      tests++;
      if (int'(sPixY) !== y) begin
        fails++;
        $error("FAIL run_pixy: observed %0d expected %0d", sPixY, y);
      end
      tests++;
      if (sHSync !== expHs) begin
        fails++;
        $error("FAIL run_hsync: observed %0d expected %0d", sHSync, expHs);
      end
      tests++;
      if (sVSync !== expVs) begin
        fails++;
        $error("FAIL run_vsync: observed %0d expected %0d", sVSync, expVs);
      end
      tests++;
      if (sDispEn !== expDe) begin
        fails++;
        $error("FAIL run_dispen: observed %0d expected %0d", sDispEn, expDe);
      end
      if (sDispEn) sDisp++;
      if (!sHSync) sHsLow++;
      if (!sVSync) sVsLow++;
      if (sLineStart) sLines++;
      if (sFrameStart) sFrames++;
      if (k < 800) begin
        if (dDispEn) dDisp++;
        if (!dHSync) begin
          if (dHsFirst < 0) dHsFirst = k;
          dHsLast = k;
          dHsLow++;
        end
        if (dLineStart) dLines++;
      end
      if (k == 800) begin
        `CHK("dflt_line2_linestart", dLineStart, 1'b1)
        `CHK("dflt_line2_pixx", int'(dPixX), 0)
        `CHK("dflt_line2_pixy", int'(dPixY), 1)
      end
      tick();
    end
    `CHK("small_dispen_total", sDisp, 240)
    `CHK("small_hsync_low_total", sHsLow, 180)
    `CHK("small_vsync_low_total", sVsLow, 160)
    `CHK("small_linestarts", sLines, 60)
    `CHK("small_framestarts", sFrames, 5)
    `CHK("small_framestart_period", sFrameStart, 1'b1)
    `CHK("dflt_dispen_per_line", dDisp, 640)
    `CHK("dflt_hsync_low_per_line", dHsLow, 96)
    `CHK("dflt_hsync_first", dHsFirst, 656)
    `CHK("dflt_hsync_last", dHsLast, 751)
    `CHK("dflt_linestarts_in_line", dLines, 1)

    // Drop Run mid-frame: the frame must complete before going idle.
    repeat (67) tick();
    `CHK("drain_at_pixy", int'(sPixY), 4)
    `CHK("drain_at_pixx", int'(sPixX), 3)
    Run = 1'b0;
    n = 0;
    while (n < 400 && sActive) begin
      lastX = int'(sPixX);
      lastY = int'(sPixY);
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $error("FAIL drain_wait: Active still high after %0d cycles", n);
    end
    `CHK("drain_cycles", n, 125)
    `CHK("drain_last_pixx", lastX, 15)
    `CHK("drain_last_pixy", lastY, 11)
    `CHK("drain_idle_pixx", int'(sPixX), 0)
    `CHK("drain_idle_pixy", int'(sPixY), 0)
    `CHK("drain_idle_hsync", sHSync, 1'b1)
    `CHK("drain_idle_vsync", sVSync, 1'b1)
    `CHK("drain_idle_dispen", sDispEn, 1'b0)
    `CHK("drain_idle_framestart", sFrameStart, 1'b0)
    repeat (5) tick();
    `CHK("drain_stays_idle", sActive, 1'b0)

    // Drop Run at line 4, re-raise at line 6: no discontinuity.
    Run = 1'b1;
    tick();
    `CHK("restart_framestart", sFrameStart, 1'b1)
    n = 0;
    inact = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (!sActive) inact++;
      if (sFrameStart) begin
        n = k;
        break;
      end
      `CHK("rerun_pixx", int'(sPixX), k % 16)
      `CHK("rerun_pixy", int'(sPixY), k / 16)
      if (k == 64) Run = 1'b0;
      if (k == 96) Run = 1'b1;
    end
    `CHK("rerun_frame_period", n, 192)
    `CHK("rerun_never_inactive", inact, 0)
    `CHK("rerun_wrap_pixx", int'(sPixX), 0)

    // Asynchronous reset mid-frame.
    repeat (87) tick();
    `CHK("midrst_pre_pixx", int'(sPixX), 7)
    `CHK("midrst_pre_pixy", int'(sPixY), 5)
    #1 RstN = 1'b0;
    #1;
    `CHK("midrst_pixx", int'(sPixX), 0)
    `CHK("midrst_pixy", int'(sPixY), 0)
    `CHK("midrst_active", sActive, 1'b0)
    `CHK("midrst_hsync", sHSync, 1'b1)
    `CHK("midrst_vsync", sVSync, 1'b1)
    `CHK("midrst_dispen", sDispEn, 1'b0)
    `CHK("midrst_dflt_pixx", int'(dPixX), 0)
    `CHK("midrst_dflt_active", dActive, 1'b0)
    Run = 1'b0;
    tick();
    @(negedge Clk);
    RstN = 1'b1;
    repeat (3) tick();
    `CHK("postrst_idle_active", sActive, 1'b0)
    `CHK("postrst_idle_framestart", sFrameStart, 1'b0)
    `CHK("postrst_idle_dispen", sDispEn, 1'b0)
    Run = 1'b1;
    tick();
    `CHK("postrst_framestart", sFrameStart, 1'b1)
    `CHK("postrst_pixx", int'(sPixX), 0)

`ifdef VGA_TIMING_FRAME_IRQ_EN
    `CHK("irq_clear_at_start", sFrameIrq, 1'b0)
    repeat (95) tick();
    `CHK("irq_before_vblank", sFrameIrq, 1'b0)
    tick();
    `CHK("irq_vblank_pixy", int'(sPixY), 6)
    `CHK("irq_set", sFrameIrq, 1'b1)
    IrqAck = 1'b1;
    tick();
    IrqAck = 1'b0;
    `CHK("irq_ack_clears", sFrameIrq, 1'b0)
    repeat (190) tick();
    IrqAck = 1'b1;
    tick();
    `CHK("irq_set_beats_ack", sFrameIrq, 1'b1)
    IrqAck = 1'b0;
    tick();
    `CHK("irq_sticky", sFrameIrq, 1'b1)
    `CHK("irq_dflt_not_set", dFrameIrq, 1'b0)
    Run = 1'b0;
    n = 0;
    while (n < 400 && sActive) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $error("FAIL irq_idle_wait: Active still high after %0d cycles", n);
    end
    `CHK("irq_idle_cycles", n, 95)
    `CHK("irq_cleared_on_idle", sFrameIrq, 1'b0)
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
